// File: rtl/online_ccm_pkg.sv
// Shared types and helpers for the sequential online constant-coefficient multiplier.
// Digits are {p,n} pairs; the value of digit i is (p-n)*2^i.
package online_ccm_pkg;

    localparam int DIGIT_W    = 2;
    localparam int MAX_DIGITS = 32;

    typedef logic [DIGIT_W*MAX_DIGITS-1:0] dvec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int dig_bits(input int n);
        return DIGIT_W * n;
    endfunction

    // Negating a redundant number is just exchanging p and n in every digit.
    function automatic dvec_t digit_swap(input dvec_t v);
        dvec_t r;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[DIGIT_W*i +: DIGIT_W] = {v[DIGIT_W*i], v[DIGIT_W*i+1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/online_adder.sv
// Carry-free signed-digit adder: z = a + b + cin, one extra transfer digit on top.
// The transfer out of each position is chosen from the sign of the position below.
module online_adder
    import online_ccm_pkg::*;
#(
    parameter int N = 14
) (
    input  logic [dig_bits(N)-1:0]   a,
    input  logic [dig_bits(N)-1:0]   b,
    input  logic                     cin,
    output logic [dig_bits(N+1)-1:0] z
);

    logic signed [2:0] s_v;
    logic signed [2:0] t_v;
    logic signed [2:0] w_v;
    logic signed [2:0] t_prev;
    logic              lo_nonneg;

    function automatic logic signed [2:0] dval(input logic [1:0] d);
        return $signed({2'b00, d[1]}) - $signed({2'b00, d[0]});
    endfunction

    function automatic logic [1:0] denc(input logic signed [2:0] v);
        logic [1:0] r;
        case (v)
            3'b001:  r = 2'b10;
            3'b111:  r = 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    always_comb begin
        z         = '0;
        s_v       = '0;
        t_v       = '0;
        w_v       = '0;
        t_prev    = $signed({2'b00, cin});
        lo_nonneg = 1'b1;
        for (int i = 0; i < N; i++) begin
            s_v = dval(a[2*i +: 2]) + dval(b[2*i +: 2]);
            t_v = '0;
            w_v = '0;
            // Pick w so that w + incoming transfer stays within {-1,0,1}.
            case (s_v)
                3'b010: t_v = 3'sd1;
                3'b110: t_v = -3'sd1;
                3'b001: begin
                    if (lo_nonneg) begin
                        t_v = 3'sd1;
                        w_v = -3'sd1;
                    end else begin
                        w_v = 3'sd1;
                    end
                end
                3'b111: begin
                    if (lo_nonneg) begin
                        w_v = -3'sd1;
                    end else begin
                        t_v = -3'sd1;
                        w_v = 3'sd1;
                    end
                end
                default: ;
            endcase
            z[2*i +: 2] = denc(w_v + t_prev);
            t_prev      = t_v;
            lo_nonneg   = ~s_v[2];
        end
        z[2*N +: 2] = denc(t_prev);
    end

endmodule

// File: rtl/online_ccm_seq.sv
// Sequential online multiplier: y = (neg ? -1 : 1) * coef * x, one adder reused
// LSB-first over the coefficient bits, stopping after the highest set bit.
module online_ccm_seq
    import online_ccm_pkg::*;
#(
    parameter int STAGE = 4,
    parameter int CW    = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [dig_bits(STAGE)-1:0]        x,
    input  logic [CW-1:0]                     coef,
    input  logic                              neg,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [dig_bits(STAGE+CW+2)-1:0]   y,
    output logic                              busy
);

    localparam int N  = STAGE + CW + 2;
    localparam int XW = dig_bits(N);

    state_e          state_q, state_d;
    logic [XW-1:0]   acc_q, acc_d;
    logic [XW-1:0]   xs_q, xs_d;
    logic [CW-1:0]   cs_q, cs_d;
    logic            neg_q, neg_d;
    logic [XW-1:0]   y_q, y_d;

    logic [XW-1:0]   addend;
    logic [XW+1:0]   z_w;
    logic [XW-1:0]   z_lo;

    assign addend = cs_q[0] ? xs_q : '0;
    assign z_lo   = z_w[XW-1:0];

    online_adder #(.N(N)) u_adder (
        .a   (acc_q),
        .b   (addend),
        .cin (1'b0),
        .z   (z_w)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        xs_d    = xs_q;
        cs_d    = cs_q;
        neg_d   = neg_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xs_d  = XW'(x);
                    cs_d  = coef;
                    acc_d = '0;
                    neg_d = neg;
                    if (coef == '0) begin
                        state_d = DONE;
                        y_d     = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = z_lo;
                xs_d  = xs_q << DIGIT_W;
                cs_d  = cs_q >> 1;
                // No higher coefficient bits left: this add is the last one.
                if (cs_q[CW-1:1] == '0) begin
                    state_d = DONE;
                    y_d     = neg_q ? XW'(digit_swap(dvec_t'(z_lo))) : z_lo;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            xs_q    <= '0;
            cs_q    <= '0;
            neg_q   <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            xs_q    <= xs_d;
            cs_q    <= cs_d;
            neg_q   <= neg_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;

    // |coef*x| < 2^(STAGE+CW) keeps the two guard digits clear, so the dropped
    // transfer digit must never carry anything.
    a_transfer_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == RUN) |-> (z_w[XW+1:XW] == 2'b00));

    a_guard_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == RUN) |-> (acc_q[XW-1:XW-4] == 4'b0 && addend[XW-1:XW-4] == 4'b0));

endmodule
